// File: rtl/seq_timing_gen.sv
`default_nettype none
// seq_timing_gen: sequence counter, run flip-flop, IR and I flip-flop of the basic computer
// control unit, with one-hot T timing and D opcode decode.
module seq_timing_gen #(
  parameter int SC_W  = 3,
  parameter int IR_W  = 16,
  parameter int OPC_W = 3
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 START,
  input  logic                 HLT,
  input  logic                 CLR,
  input  logic                 INC,
  input  logic [IR_W-1:0]      IR_IN,
  output logic [2**SC_W-1:0]   T,
  output logic [2**OPC_W-1:0]  D,
  output logic                 I,
  output logic                 S,
  output logic [SC_W-1:0]      SC,
  output logic [IR_W-1:0]      IR
);

  logic [OPC_W-1:0] opcode;

  assign opcode = IR[IR_W-2 -: OPC_W];

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      SC <= '0;
      S  <= 1'b0;
      IR <= '0;
      I  <= 1'b0;
    end else begin
      // Loads use the pre-edge S, so a halt on the same edge still lets them happen.
      if (S && T[1]) IR <= IR_IN;
      if (S && T[2]) I  <= IR[IR_W-1];

      if (S && HLT) begin
        S  <= 1'b0;
        SC <= '0;
      end else if (!S && START && !HLT) begin
        S  <= 1'b1;
        SC <= '0;
      end else if (S) begin
        if (CLR)      SC <= '0;
        else if (INC) SC <= SC + 1'b1;
      end
    end
  end

  always_comb begin
    T = '0;
    if (S) T[SC] = 1'b1;
  end

  always_comb begin
    D = '0;
    D[opcode] = 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_timing_gen.sv
`default_nettype none
// Scoreboard bench for seq_timing_gen: driver pushes model predictions, monitor pops and compares.
module tb_seq_timing_gen;
  localparam int SC_W  = 3;
  localparam int IR_W  = 16;
  localparam int OPC_W = 3;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0, START = 1'b0, HLT = 1'b0, CLR = 1'b0, INC = 1'b0;
  logic [IR_W-1:0]   IR_IN = '0;
  logic [7:0]        T, D;
  logic              I, S;
  logic [SC_W-1:0]   SC;
  logic [IR_W-1:0]   IR;

  always #5 CLK = ~CLK;

  seq_timing_gen #(.SC_W(SC_W), .IR_W(IR_W), .OPC_W(OPC_W)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .HLT(HLT), .CLR(CLR), .INC(INC),
    .IR_IN(IR_IN), .T(T), .D(D), .I(I), .S(S), .SC(SC), .IR(IR)
  );

  typedef struct {
    logic [7:0]  t;
    logic [7:0]  d;
    logic        i;
    logic        s;
    logic [2:0]  sc;
    logic [15:0] ir;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state of the control unit as the rules describe it.
  bit          m_s;
  int          m_sc;
  logic [15:0] m_ir;
  bit          m_i;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic rstn, input logic start, input logic hlt,
                      input logic clr, input logic inc, input logic [15:0] irin);
    exp_t e;
    bit   n_s;
    int   n_sc;
    @(negedge CLK);
    RSTN = rstn; START = start; HLT = hlt; CLR = clr; INC = inc; IR_IN = irin;
    @(posedge CLK);
    if (!rstn) begin
      m_s = 0; m_sc = 0; m_ir = '0; m_i = 0;
    end else begin
      n_s  = m_s;
      n_sc = m_sc;
      if (m_s && hlt)                  begin n_s = 0; n_sc = 0; end
      else if (!m_s && start && !hlt)  begin n_s = 1; n_sc = 0; end
      else if (m_s && clr)             n_sc = 0;
      else if (m_s && inc)             n_sc = (m_sc + 1) % 8;
      if (m_s && m_sc == 2) m_i = m_ir[15];
      if (m_s && m_sc == 1) m_ir = irin;
      m_s  = n_s;
      m_sc = n_sc;
    end
    e.t  = m_s ? 8'(1 << m_sc) : 8'h00;
    e.d  = 8'(1 << m_ir[14:12]);
    e.i  = m_i;
    e.s  = m_s;
    e.sc = 3'(m_sc);
    e.ir = m_ir;
    q.push_back(e);
  endtask

  task automatic run_to(input int k, input logic [15:0] irin);
    for (int n = 0; n < 10 && m_sc != k; n++) step(1, 0, 0, 0, 1, irin);
  endtask

  // Monitor: outputs are settled one time unit after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("T",  32'(T),  32'(e.t));
        cmp("D",  32'(D),  32'(e.d));
        cmp("S",  32'(S),  32'(e.s));
        cmp("SC", 32'(SC), 32'(e.sc));
        cmp("IR", 32'(IR), 32'(e.ir));
        cmp("I",  32'(I),  32'(e.i));
      end
    end
  end

  initial begin
    m_s = 0; m_sc = 0; m_ir = '0; m_i = 0;
    step(0, 0, 0, 0, 0, 16'h0000);
    step(0, 1, 0, 1, 1, 16'h1234);

    // Start and walk T0..T7 with wrap; IR loads A123 at T1, I set at T2.
    step(1, 1, 0, 0, 1, 16'hA123);
    repeat (9) step(1, 0, 0, 0, 1, 16'hA123);

    // CLR and INC together at T3: CLR wins.
    run_to(3, 16'hA123);
    step(1, 0, 0, 1, 1, 16'hA123);

    // Halt at T4, then INC ignored, then restart.
    run_to(4, 16'h5555);
    step(1, 0, 1, 0, 1, 16'h5555);
    repeat (3) step(1, 0, 0, 0, 1, 16'h5555);
    step(1, 1, 0, 0, 1, 16'h5555);

    // Halt on a T1 load edge: load still happens.
    run_to(1, 16'h3C3C);
    step(1, 0, 1, 0, 1, 16'h3C3C);

    // START and HLT together while stopped.
    step(1, 1, 1, 0, 1, 16'h0000);
    step(1, 0, 0, 1, 1, 16'h0000);

    // Reset at T5 with IR=FFFF, I=1.
    step(1, 1, 0, 0, 1, 16'hFFFF);
    run_to(5, 16'hFFFF);
    step(0, 0, 0, 0, 1, 16'hFFFF);
    step(1, 0, 0, 0, 1, 16'hFFFF);

    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(63) != 0), ($urandom_range(7) == 0), ($urandom_range(15) == 0),
           ($urandom_range(7) == 0), ($urandom_range(3) != 0), 16'($urandom));
    end

    repeat (3) @(posedge CLK);
    #2;
    cmp("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
